// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, the data port and the SRAM bus of the
// IF/MEM memory arbiter.
//   slave  modport: the arbiter view. It receives the requests and sram_rdata, and it
//                   drives the ready/rdata/freeze outputs and the SRAM strobes.
//   master modport: the pipeline + SRAM view, which is the mirror image of slave.
// Parameter ADDR_W is the SRAM word-address width. It must match the arbiter's ADDR_W.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    // Fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    // Data port
    logic              mem_r_en;
    logic              mem_w_en;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              freeze;
    // SRAM bus
    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output if_req, if_addr, mem_r_en, mem_w_en, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported word SRAM between instruction fetch (IF) and
// data load/store (MEM). Each access holds the bus for WAIT_STATES+1 cycles and is
// followed by a one-cycle DONE state that pulses the owner's ready. A data request
// always wins over a fetch. freeze stalls the pipeline while a data access is pending.
// Ports:
//   clk, reset   : rising-edge clock and synchronous active-high reset
//   bus (slave)  : fetch port (if_*), data port (mem_*, freeze) and SRAM bus (sram_*)
//   perf_if_wait : saturating count of cycles with if_req & ~if_ready  (optional)
//   perf_mem_wait: saturating count of cycles with freeze asserted     (optional)
// Build option: define MEM_ARB_PERF_CNT_EN to add the two perf counter outputs.
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    mem_arbiter_if.slave       bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_if_wait,
    output logic [31:0]        perf_mem_wait
`endif
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                we_q,        we_d;
    logic                sram_en_q,   sram_en_d;
    logic                if_ready_q,  if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_req_c;
    logic                freeze_c;

    // Byte-address bits outside the SRAM word range are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                                bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    assign mem_req_c = bus.mem_r_en | bus.mem_w_en;
    assign freeze_c  = mem_req_c & ~mem_ready_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        sram_en_d   = sram_en_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_req_c) begin
                    state_d   = MEM_ACC;
                    cnt_d     = CNT_W'(WAIT_STATES);
                    addr_d    = bus.mem_addr[ADDR_W+1:2];
                    wdata_d   = bus.mem_wdata;
                    we_d      = bus.mem_w_en;  // a store wins over a load
                    sram_en_d = 1'b1;
                end else if (bus.if_req) begin
                    state_d   = IF_ACC;
                    cnt_d     = CNT_W'(WAIT_STATES);
                    addr_d    = bus.if_addr[ADDR_W+1:2];
                    we_d      = 1'b0;
                    sram_en_d = 1'b1;
                end
            end

            IF_ACC, MEM_ACC: begin
                if (cnt_q == CNT_W'(0)) begin
                    // Last bus cycle: sample the SRAM and release the bus
                    state_d   = DONE;
                    sram_en_d = 1'b0;
                    we_d      = 1'b0;
                    if (state_q == MEM_ACC) begin
                        mem_ready_d = 1'b1;
                        if (!we_q) begin
                            mem_rdata_d = bus.sram_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // No grant here, so a requester still holding its request on the ready
            // edge is not granted a second time.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_q,  perf_if_d;
    logic [31:0] perf_mem_q, perf_mem_d;

    // Saturating stall counters
    always_comb begin
        perf_if_d  = perf_if_q;
        perf_mem_d = perf_mem_q;
        if (bus.if_req && !if_ready_q && (perf_if_q != 32'hFFFF_FFFF)) begin
            perf_if_d = perf_if_q + 32'd1;
        end
        if (freeze_c && (perf_mem_q != 32'hFFFF_FFFF)) begin
            perf_mem_d = perf_mem_q + 32'd1;
        end
    end

    assign perf_if_wait  = perf_if_q;
    assign perf_mem_wait = perf_mem_q;
`endif

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sram_en_q   <= 1'b0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
`ifdef MEM_ARB_PERF_CNT_EN
            perf_if_q   <= '0;
            perf_mem_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            sram_en_q   <= sram_en_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef MEM_ARB_PERF_CNT_EN
            perf_if_q   <= perf_if_d;
            perf_mem_q  <= perf_mem_d;
`endif
        end
    end

    assign bus.sram_en    = sram_en_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.freeze     = freeze_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed testbench for mem_arbiter. Instance A has WAIT_STATES=2 and
// is backed by a word-array SRAM model. Instance B has WAIT_STATES=0 and a pattern
// SRAM. Defining MEM_ARB_PERF_CNT_EN enables the perf counter checks.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16)) bus_a ();
    mem_arbiter_if #(.ADDR_W(16)) bus_b ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_a, perf_mem_a, perf_if_b, perf_mem_b;
`endif

    mem_arbiter #(.WAIT_STATES(2), .ADDR_W(16)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_a)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_wait  (perf_if_a),
        .perf_mem_wait (perf_mem_a)
`endif
    );

    mem_arbiter #(.WAIT_STATES(0), .ADDR_W(16)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_b)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .perf_if_wait  (perf_if_b),
        .perf_mem_wait (perf_mem_b)
`endif
    );

    // SRAM model for A: asynchronous read, write on the clock edge, fixed words preloaded in reset
    logic [31:0] sram_a [0:65535];

    assign bus_a.sram_rdata = sram_a[bus_a.sram_addr];

    always @(posedge clk) begin
        if (reset) begin
            sram_a[16'h0004] <= 32'hE3A0_1005;
            sram_a[16'h0008] <= 32'h1234_5678;
            sram_a[16'hC004] <= 32'hCAFE_F00D;
        end else if (bus_a.sram_en && bus_a.sram_we) begin
            sram_a[bus_a.sram_addr] <= bus_a.sram_wdata;
        end
    end

    // Pattern SRAM for B: each word returns its own address in the low half
    assign bus_b.sram_rdata = {16'hA5A5, bus_b.sram_addr};

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well before the next edge
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus_a.if_req    = 1'b0;
        bus_a.if_addr   = 32'h0;
        bus_a.mem_r_en  = 1'b0;
        bus_a.mem_w_en  = 1'b0;
        bus_a.mem_addr  = 32'h0;
        bus_a.mem_wdata = 32'h0;
        bus_b.if_req    = 1'b0;
        bus_b.if_addr   = 32'h0;
        bus_b.mem_r_en  = 1'b0;
        bus_b.mem_w_en  = 1'b0;
        bus_b.mem_addr  = 32'h0;
        bus_b.mem_wdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset state
        tick();
        tick();
        settle();
        check_eq("rst_sram_en",    32'(bus_a.sram_en),    32'h0);
        check_eq("rst_sram_we",    32'(bus_a.sram_we),    32'h0);
        check_eq("rst_sram_addr",  32'(bus_a.sram_addr),  32'h0);
        check_eq("rst_sram_wdata", bus_a.sram_wdata,      32'h0);
        check_eq("rst_if_ready",   32'(bus_a.if_ready),   32'h0);
        check_eq("rst_mem_ready",  32'(bus_a.mem_ready),  32'h0);
        check_eq("rst_if_rdata",   bus_a.if_rdata,        32'h0);
        check_eq("rst_mem_rdata",  bus_a.mem_rdata,       32'h0);
        check_eq("rst_freeze",     32'(bus_a.freeze),     32'h0);
        tick();
        reset = 1'b0;

        // Single fetch of word 4
        tick();
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 32'h0000_0010;
        settle();
        check_eq("f1_c0_sram_en", 32'(bus_a.sram_en), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
            check_eq($sformatf("f1_c%0d_sram_en", c), 32'(bus_a.sram_en), (c <= 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("f1_c%0d_if_ready", c), 32'(bus_a.if_ready), (c == 4) ? 32'h1 : 32'h0);
            if (c <= 3) check_eq($sformatf("f1_c%0d_sram_addr", c), 32'(bus_a.sram_addr), 32'h4);
            if (c == 4) check_eq("f1_if_rdata", bus_a.if_rdata, 32'hE3A0_1005);
        end
        tick();
        bus_a.if_req = 1'b0;
        settle();
        check_eq("f1_done_ready_gone", 32'(bus_a.if_ready), 32'h0);

        // Store 0xDEADBEEF to byte address 0x400, then load it back
        tick();
        bus_a.mem_w_en  = 1'b1;
        bus_a.mem_addr  = 32'h0000_0400;
        bus_a.mem_wdata = 32'hDEAD_BEEF;
        settle();
        check_eq("st_c0_freeze", 32'(bus_a.freeze), 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
            check_eq($sformatf("st_c%0d_sram_we", c), 32'(bus_a.sram_we), (c <= 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("st_c%0d_freeze", c), 32'(bus_a.freeze), (c <= 3) ? 32'h1 : 32'h0);
            check_eq($sformatf("st_c%0d_mem_ready", c), 32'(bus_a.mem_ready), (c == 4) ? 32'h1 : 32'h0);
            if (c <= 3) begin
                check_eq($sformatf("st_c%0d_sram_addr", c), 32'(bus_a.sram_addr), 32'h100);
                check_eq($sformatf("st_c%0d_sram_wdata", c), bus_a.sram_wdata, 32'hDEAD_BEEF);
            end
        end
        check_eq("st_mem_rdata_kept", bus_a.mem_rdata, 32'h0);
        tick();
        bus_a.mem_w_en = 1'b0;
        settle();
        check_eq("st_sram_word", sram_a[16'h0100], 32'hDEAD_BEEF);

        tick();
        bus_a.mem_r_en = 1'b1;
        bus_a.mem_addr = 32'h0000_0400;
        for (int c = 1; c <= 4; c++) begin
            tick();
            settle();
            check_eq($sformatf("ld_c%0d_sram_we", c), 32'(bus_a.sram_we), 32'h0);
            check_eq($sformatf("ld_c%0d_mem_ready", c), 32'(bus_a.mem_ready), (c == 4) ? 32'h1 : 32'h0);
        end
        check_eq("ld_mem_rdata", bus_a.mem_rdata, 32'hDEAD_BEEF);
        tick();
        bus_a.mem_r_en = 1'b0;

        // Fetch and load raised together: the load is served first, with no overlap
        do_reset();
        tick();
        bus_a.if_req   = 1'b1;
        bus_a.if_addr  = 32'h0000_0020;
        bus_a.mem_r_en = 1'b1;
        bus_a.mem_addr = 32'h0000_0400;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 5)  bus_a.mem_r_en = 1'b0;
            if (c == 10) bus_a.if_req   = 1'b0;
            settle();
            check_eq($sformatf("cf_c%0d_mem_ready", c), 32'(bus_a.mem_ready), (c == 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("cf_c%0d_if_ready", c), 32'(bus_a.if_ready), (c == 9) ? 32'h1 : 32'h0);
            if (c == 2) check_eq("cf_mem_addr", 32'(bus_a.sram_addr), 32'h100);
            if (c == 7) check_eq("cf_if_addr", 32'(bus_a.sram_addr), 32'h8);
        end
        check_eq("cf_mem_rdata", bus_a.mem_rdata, 32'hDEAD_BEEF);
        check_eq("cf_if_rdata", bus_a.if_rdata, 32'h1234_5678);
`ifdef MEM_ARB_PERF_CNT_EN
        check_eq("perf_mem_wait", perf_mem_a, 32'd4);
        check_eq("perf_if_wait", perf_if_a, 32'd9);
`endif

        // Reset in the second bus cycle of a store aborts it
        tick();
        bus_a.mem_w_en  = 1'b1;
        bus_a.mem_addr  = 32'h0000_0800;
        bus_a.mem_wdata = 32'h5555_AAAA;
        tick();
        tick();
        reset = 1'b1;
        bus_a.mem_w_en = 1'b0;
        settle();
        check_eq("ra_pre_sram_we", 32'(bus_a.sram_we), 32'h1);
        tick();
        reset = 1'b0;
        settle();
        check_eq("ra_sram_en", 32'(bus_a.sram_en), 32'h0);
        check_eq("ra_sram_we", 32'(bus_a.sram_we), 32'h0);
        check_eq("ra_freeze", 32'(bus_a.freeze), 32'h0);
        check_eq("ra_mem_ready", 32'(bus_a.mem_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            check_eq($sformatf("ra_idle%0d_mem_ready", c), 32'(bus_a.mem_ready), 32'h0);
            check_eq($sformatf("ra_idle%0d_sram_en", c), 32'(bus_a.sram_en), 32'h0);
        end

        // Held fetch requests: A (2 wait states) and B (0 wait states) side by side.
        // A also checks that the byte address wraps into the 16-bit word space.
        tick();
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 32'hFFFF_0013;
        bus_b.if_req  = 1'b1;
        bus_b.if_addr = 32'h0000_0008;
        for (int c = 1; c <= 30; c++) begin
            tick();
            settle();
            check_eq($sformatf("bb_a_c%0d_if_ready", c), 32'(bus_a.if_ready), ((c % 5) == 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("bb_b_c%0d_if_ready", c), 32'(bus_b.if_ready), ((c % 3) == 2) ? 32'h1 : 32'h0);
            if (c == 1) begin
                check_eq("bb_a_wrap_addr", 32'(bus_a.sram_addr), 32'hC004);
                check_eq("bb_b_c1_sram_en", 32'(bus_b.sram_en), 32'h1);
            end
            if (c == 2) check_eq("bb_b_if_rdata", bus_b.if_rdata, 32'hA5A5_0002);
            if (c == 4) check_eq("bb_a_if_rdata", bus_a.if_rdata, 32'hCAFE_F00D);
        end
        tick();
        idle_inputs();
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
